// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS memory subsystem.
// Owner encoding is used by the arbiter and the read-return router.
package mips_defs;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// One requester port of the memory arbiter: request, address, data and the grant/read return.
// The requester drives through master; the arbiter receives through slave.
interface mips_mem_arbiter_if #(
    parameter int unsigned WIDTH = mips_defs::DEF_WIDTH
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (output req, we, adr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, adr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_rdata_router.sv
// Remembers who issued last cycle's read and steers the memory read data back to that port.
// Outputs are forced low while reset is high so an in-flight read never surfaces.
module mem_rdata_router
    import mips_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    input  owner_t           rd_owner,
    input  logic [WIDTH-1:0] memdata,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             host_rvalid,
    output logic [WIDTH-1:0] host_rdata
);
    logic   valid_q;
    owner_t owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            owner_q <= OWN_NONE;
        end else begin
            valid_q <= rd_valid;
            owner_q <= rd_owner;
        end
    end

    always_comb begin
        cpu_rvalid  = !reset && valid_q && (owner_q == OWN_CPU);
        host_rvalid = !reset && valid_q && (owner_q == OWN_HOST);
        cpu_rdata   = cpu_rvalid ? memdata : '0;
        host_rdata  = host_rvalid ? memdata : '0;
    end
endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the single-ported unified memory between the CPU and the host load/debug port.
// CPU has priority; the wait counter forces a host grant after MAXWAIT denied cycles.
module mips_mem_arbiter
    import mips_defs::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mips_mem_arbiter_if.slave cpu,
    mips_mem_arbiter_if.slave host,
    input  logic              host_lock,
    output logic [WIDTH-1:0]  adr,
    output logic [WIDTH-1:0]  writedata,
    output logic              memwrite,
    output logic              memread,
    input  logic [WIDTH-1:0]  memdata
);
    localparam logic [3:0] MaxWait = 4'(MAXWAIT);

    owner_t     sel;
    owner_t     last_q;
    logic [3:0] waitcnt_q;
    logic [3:0] waitcnt_d;
    logic       host_due;

    assign host_due = host.req && (waitcnt_q == MaxWait);

    always_comb begin
        sel = OWN_NONE;
        if (reset) begin
            sel = OWN_NONE;
        end else if (host_lock) begin
            sel = host.req ? OWN_HOST : OWN_NONE;
        end else if (host_due) begin
            sel = OWN_HOST;
        end else if (cpu.req) begin
            sel = OWN_CPU;
        end else if (host.req) begin
            sel = OWN_HOST;
        end
    end

    assign cpu.gnt  = (sel == OWN_CPU);
    assign host.gnt = (sel == OWN_HOST);

    always_comb begin
        adr       = '0;
        writedata = '0;
        memwrite  = 1'b0;
        memread   = 1'b0;
        unique case (sel)
            OWN_CPU: begin
                adr       = cpu.adr;
                writedata = cpu.wdata;
                memwrite  = cpu.we;
                memread   = !cpu.we;
            end
            OWN_HOST: begin
                adr       = host.adr;
                writedata = host.wdata;
                memwrite  = host.we;
                memread   = !host.we;
            end
            default: ;
        endcase
    end

    always_comb begin
        waitcnt_d = waitcnt_q;
        if (!host.req || (sel == OWN_HOST)) begin
            waitcnt_d = '0;
        end else if (waitcnt_q < MaxWait) begin
            waitcnt_d = waitcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitcnt_q <= '0;
            last_q    <= OWN_NONE;
        end else begin
            waitcnt_q <= waitcnt_d;
            last_q    <= sel;
        end
    end

    // A host grant always leaves the starvation counter cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(last_q == OWN_HOST && waitcnt_q != 4'd0));
        end
    end

    mem_rdata_router #(
        .WIDTH(WIDTH)
    ) u_router (
        .clk        (clk),
        .reset      (reset),
        .rd_valid   (memread),
        .rd_owner   (sel),
        .memdata    (memdata),
        .cpu_rvalid (cpu.rvalid),
        .cpu_rdata  (cpu.rdata),
        .host_rvalid(host.rvalid),
        .host_rdata (host.rdata)
    );
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized scoreboard bench: a reference model predicts grants and read returns,
// a separate monitor checks every read return against the expected queue.
module tb_mips_mem_arbiter;
    localparam int MAXW = 4;

    logic       clk;
    logic       reset;
    logic       host_lock;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memwrite;
    logic       memread;
    logic [7:0] memdata;

    mips_mem_arbiter_if #(.WIDTH(8)) cpu_if ();
    mips_mem_arbiter_if #(.WIDTH(8)) host_if ();

    mips_mem_arbiter #(
        .WIDTH  (8),
        .MAXWAIT(MAXW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_if),
        .host     (host_if),
        .host_lock(host_lock),
        .adr      (adr),
        .writedata(writedata),
        .memwrite (memwrite),
        .memread  (memread),
        .memdata  (memdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: one-cycle read latency, refilled with a known pattern on reset.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (memwrite) mem[adr] <= writedata;
            if (memread) memdata <= mem[adr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    typedef struct {
        int         due;
        int         owner;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [7:0] gold [256];
    int wait_m = 0;
    int prev_e = 0;
    int dut_cgnt, dut_hgnt;

    task automatic tick(output int g);
        int e;
        logic we;
        logic [7:0] a, wd;
        @(negedge clk);
        if (reset) e = 0;
        else if (host_lock) e = host_if.req ? 2 : 0;
        else if (host_if.req && wait_m >= MAXW) e = 2;
        else if (cpu_if.req) e = 1;
        else if (host_if.req) e = 2;
        else e = 0;
        we = (e == 1) ? cpu_if.we : host_if.we;
        a  = (e == 1) ? cpu_if.adr : host_if.adr;
        wd = (e == 1) ? cpu_if.wdata : host_if.wdata;
        dut_cgnt = int'(cpu_if.gnt);
        dut_hgnt = int'(host_if.gnt);
        check("cpu_gnt", dut_cgnt, int'(e == 1));
        check("host_gnt", dut_hgnt, int'(e == 2));
        check("memwrite", int'(memwrite), int'(e != 0 && we));
        check("memread", int'(memread), int'(e != 0 && !we));
        check("adr", int'(adr), (e != 0) ? int'(a) : 0);
        check("writedata", int'(writedata), (e != 0) ? int'(wd) : 0);
        check("last", int'(dut.last_q), prev_e);
        if (reset) begin
            for (int i = 0; i < 256; i++) gold[i] = 8'(i * 7 + 3);
        end else if (e != 0) begin
            if (we) gold[a] = wd;
            else sbq.push_back('{due: cyc + 1, owner: e, data: gold[a]});
        end
        if (reset || !host_if.req || e == 2) wait_m = 0;
        else if (wait_m < MAXW) wait_m++;
        prev_e = e;
        g = e;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int eo;
        logic [7:0] ed;
        eo = 0;
        ed = 8'h00;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            eo = reset ? 0 : sbq[0].owner;
            ed = sbq[0].data;
            void'(sbq.pop_front());
        end
        check("cpu_rvalid", int'(cpu_if.rvalid), int'(eo == 1));
        check("cpu_rdata", int'(cpu_if.rdata), (eo == 1) ? int'(ed) : 0);
        check("host_rvalid", int'(host_if.rvalid), int'(eo == 2));
        check("host_rdata", int'(host_if.rdata), (eo == 2) ? int'(ed) : 0);
    end

    function automatic logic [7:0] rnd_adr();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
    endfunction

    task automatic new_cpu();
        cpu_if.req   = ($urandom_range(0, 9) < 7);
        cpu_if.we    = 1'($urandom_range(0, 1));
        cpu_if.adr   = rnd_adr();
        cpu_if.wdata = 8'($urandom);
    endtask

    task automatic new_host();
        host_if.req   = ($urandom_range(0, 9) < 5);
        host_if.we    = 1'($urandom_range(0, 1));
        host_if.adr   = rnd_adr();
        host_if.wdata = 8'($urandom);
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cpu_if.req = r; cpu_if.we = w; cpu_if.adr = a; cpu_if.wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        host_if.req = r; host_if.we = w; host_if.adr = a; host_if.wdata = d;
    endtask

    initial begin
        int g, nh, nc;
        reset = 1'b1;
        host_lock = 1'b0;
        set_cpu(1'b1, 1'b0, 8'h05, 8'h00);
        set_host(1'b1, 1'b1, 8'h06, 8'h99);

        // Reset with both requesting; CPU wins first after release
        repeat (3) tick(g);
        reset = 1'b0;
        tick(g);
        check("first_gnt_cpu", dut_cgnt, 1);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        tick(g);
        set_host(1'b0, 1'b0, 8'h00, 8'h00);
        tick(g);

        // Host alone: write EE then read it back
        set_host(1'b1, 1'b1, 8'hEE, 8'hF2);
        tick(g);
        set_host(1'b1, 1'b0, 8'hEE, 8'h00);
        tick(g);
        set_host(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick(g);

        // Continuous contention: C,C,C,C,H repeating
        nh = 0;
        set_cpu(1'b1, 1'b0, 8'h01, 8'h00);
        set_host(1'b1, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick(g);
            nh += dut_hgnt;
            if (g == 1) cpu_if.adr = 8'($urandom_range(0, 15));
            if (g == 2) host_if.adr = host_if.adr + 8'd1;
        end
        check("contention_host_gnts", nh, 3);

        // host_lock with CPU requesting: host reads 00..03 in order
        nc = 0;
        host_lock = 1'b1;
        set_cpu(1'b1, 1'b0, 8'h40, 8'h00);
        for (int i = 0; i < 4; i++) begin
            set_host(1'b1, 1'b0, 8'(i), 8'h00);
            tick(g);
            nc += dut_cgnt;
        end
        set_host(1'b0, 1'b0, 8'h00, 8'h00);
        tick(g);
        nc += dut_cgnt;
        check("lock_cpu_gnts", nc, 0);
        host_lock = 1'b0;
        tick(g);
        check("cpu_after_unlock", dut_cgnt, 1);

        // Alternating reads by CPU then host
        set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        tick(g);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_host(1'b1, 1'b0, 8'h20, 8'h00);
        tick(g);
        set_host(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick(g);

        // Reset in the cycle after a CPU read grant suppresses its rvalid
        set_cpu(1'b1, 1'b0, 8'h50, 8'h00);
        tick(g);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        tick(g);
        reset = 1'b0;
        repeat (2) tick(g);

        // Randomized traffic
        new_cpu();
        new_host();
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) host_lock = ~host_lock;
            tick(g);
            if (g == 1 || !cpu_if.req) new_cpu();
            if (g == 2 || !host_if.req) new_host();
        end

        reset = 1'b0;
        host_lock = 1'b0;
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_host(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick(g);
        check("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-ported 8-bit unified memory of the multicycle MIPS between two requesters: the CPU and a host port used for program loading and debug (load, peek, poke).
- Sits between the mips core and the memory inside mips_mem.
- Grants one access per cycle: CPU has priority, and a starvation counter guarantees the host progresses.
- Returns read data one cycle after the grant and routes it to the requester that issued the read.

Parameters:
- WIDTH, 8, data and address width in bits.
- MAXWAIT, 4, max consecutive cycles the host is denied while requesting; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_adr  in  WIDTH  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle; CPU stalls while cpu_req=1 and cpu_gnt=0.
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a CPU read grant).
- cpu_rdata  out  WIDTH  CPU read data.
- host_req, host_we, host_adr, host_wdata  in  1/1/WIDTH/WIDTH  same semantics as the CPU inputs.
- host_gnt, host_rvalid, host_rdata  out  1/1/WIDTH  same semantics as the CPU outputs.
- host_lock  in  1  while 1, CPU is never granted (program load).
- adr  out  WIDTH  memory address.
- writedata  out  WIDTH  memory write data.
- memwrite  out  1  memory write strobe.
- memread  out  1  memory read strobe.
- memdata  in  WIDTH  memory read data, valid the cycle after memread.

Behaviour:
Reset and grant timing:
- One clock, clk. Reset is synchronous and active-high: all registers update only on the rising edge of clk, and reset is sampled there.
- While reset=1: cpu_gnt=host_gnt=0, memwrite=memread=0, both rvalid=0, adr=writedata=0, wait counter=0, last=NONE.
- Grants are combinational from the req inputs and registered state; the memory access happens in the same cycle as the grant. Zero added latency when uncontested.

Arbitration (at most one grant per cycle):
- host_lock=1: host granted if host_req, else nothing.
- else if host_req and waitcnt==MAXWAIT: host granted.
- else if cpu_req: CPU granted.
- else if host_req: host granted.
- else: idle.

Wait counter (waitcnt, 4 bits):
- Increments each cycle host_req=1 and host_gnt=0, saturating at MAXWAIT.
- Clears to 0 on any host grant, or whenever host_req=0.

Last-winner register (last):
- States NONE/CPU/HOST; set to the granted owner each cycle, NONE when idle.
- Drives no outputs; it exists for debug visibility and for the bench to probe.

Memory side:
- adr, writedata, memwrite=we, memread=~we are muxed from the granted port.
- When idle, all are 0.

Read return:
- A one-stage register holds {valid, owner}.
- Cycle N+1 after a read grant in cycle N: owner's rvalid=1 and rdata=memdata; the other port's rvalid=0.
- rdata is 0 when its rvalid=0.
- Write grants produce no rvalid.

Boundary conditions:
- Back-to-back reads by alternating owners: each rvalid is routed correctly, one per cycle.
- Reset asserted the cycle after a read grant: that rvalid is suppressed (0).
- Reset mid-stream: no grant in any reset cycle; requests must be re-held after reset.
- Simultaneous CPU and host write to the same address: only one write is performed per cycle, in priority order, so the later writer's data persists.
- host_lock rising while the CPU is requesting: CPU gets no grant from that cycle on.
- MAXWAIT=1: host and CPU alternate under continuous contention.

Decomposition:
- Shared package mips_defs:
  - owner encoding: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HOST=2'd2.
  - WIDTH default.
- One natural sub-module, mem_rdata_router: the registered {valid, owner} stage plus the rdata/rvalid demux.
- Arbitration and the wait counter stay in the top module.

Test Plan:
- Reset held 3 cycles with cpu_req=host_req=1 -> no gnt, memwrite=0, rvalid=0 throughout; first grant goes to the CPU in the cycle after reset deasserts.
- Host alone writes adr=8'hEE, wdata=8'hF2, then reads 8'hEE -> host_gnt same cycle; memwrite=1 with adr=EE, writedata=F2; host_rvalid=1 with host_rdata=F2 one cycle after the read grant; cpu_rvalid stays 0.
- Continuous cpu_req and host_req, MAXWAIT=4 -> grant pattern C,C,C,C,H repeating; waitcnt clears after each H.
- host_lock=1 with cpu_req held -> cpu_gnt=0 for all lock cycles; host reads 8'h00..8'h03 return in order; CPU granted in the first cycle after host_lock=0.
- Alternating reads: CPU at 8'h10 (cycle N), host at 8'h20 (cycle N+1) -> cpu_rvalid at N+1, host_rvalid at N+2, each with its own memdata.
- Reset asserted the cycle after a CPU read grant -> cpu_rvalid stays 0; no spurious memread.
